// File: rtl/input_interface.sv
// Byte-serial AES ingress: packs 16 bytes (MSB first) into a 128-bit block, held in a one-deep output stage.
// Latency: block valid one edge after its 16th byte; input_ready drops while a full block waits for ack.
module input_interface #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic [7:0]   data_in,
    input  logic         data_ok,
    output logic         input_ready,
    output logic [127:0] plaintext,
    output logic         plaintext_valid,
    input  logic         plaintext_ack,
    output logic         frame_err,
    output logic         overrun_err,
    output logic [4:0]   byte_count
);

    localparam int GW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TMO_EN = (TIMEOUT > 0);
    localparam logic [GW-1:0] GAP_LAST = GW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ASM_EMPTY,
        ASM_COLLECT,
        ASM_FULL
    } asm_state_t;

    asm_state_t     asm_state;
    logic [127:0]   asm_q;
    logic [127:0]   asm_d;
    logic [4:0]     count_d;
    logic [GW-1:0]  gap_q;
    logic [GW-1:0]  gap_d;
    logic [127:0]   pt_d;
    logic           pv_d;
    logic           ferr_d;
    logic           oerr_d;
    logic           accept;
    logic           xfer;
    logic           timeout;

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            asm_q           <= '0;
            byte_count      <= '0;
            gap_q           <= '0;
            plaintext       <= '0;
            plaintext_valid <= 1'b0;
            frame_err       <= 1'b0;
            overrun_err     <= 1'b0;
        end else begin
            asm_q           <= asm_d;
            byte_count      <= count_d;
            gap_q           <= gap_d;
            plaintext       <= pt_d;
            plaintext_valid <= pv_d;
            frame_err       <= ferr_d;
            overrun_err     <= oerr_d;
        end
    end

    always_comb begin
        if (byte_count == 5'd0) begin
            asm_state = ASM_EMPTY;
        end else if (byte_count[4]) begin
            asm_state = ASM_FULL;
        end else begin
            asm_state = ASM_COLLECT;
        end

        input_ready = (asm_state != ASM_FULL);
        accept      = data_ok && input_ready;
        xfer        = (asm_state == ASM_FULL) && (!plaintext_valid || plaintext_ack);
        // The gap counter value before the edge decides the timeout, so a byte
        // landing on that same edge is swallowed along with the partial block.
        timeout     = TMO_EN && (asm_state == ASM_COLLECT) && (gap_q == GAP_LAST);

        asm_d   = asm_q;
        count_d = byte_count;
        gap_d   = gap_q;
        pt_d    = plaintext;
        pv_d    = plaintext_valid;
        ferr_d  = 1'b0;
        oerr_d  = data_ok && !input_ready;

        case (asm_state)
            ASM_EMPTY: begin
                gap_d = '0;
                if (accept) begin
                    asm_d   = {asm_q[119:0], data_in};
                    count_d = byte_count + 5'd1;
                end
            end
            ASM_FULL: begin
                gap_d = '0;
                if (xfer) begin
                    pt_d    = asm_q;
                    pv_d    = 1'b1;
                    count_d = 5'd0;
                end
            end
            default: begin
                if (timeout) begin
                    asm_d   = '0;
                    count_d = 5'd0;
                    gap_d   = '0;
                    ferr_d  = 1'b1;
                end else if (accept) begin
                    asm_d   = {asm_q[119:0], data_in};
                    count_d = byte_count + 5'd1;
                    gap_d   = '0;
                end else if (TMO_EN) begin
                    gap_d = gap_q + 1'b1;
                end
            end
        endcase

        // An ack that does not coincide with a transfer retires the held block.
        if (!xfer && plaintext_valid && plaintext_ack) begin
            pv_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_input_interface.sv
// Bench for input_interface: three instances (TIMEOUT 16/4/0) on shared stimulus, each against a byte-level model.
module tb_input_interface;

    logic         clk = 1'b0;
    logic         rst_ = 1'b1;
    logic [7:0]   d_in = 8'h00;
    logic         ok = 1'b0;
    logic         ack = 1'b0;

    logic         rdy [3];
    logic [127:0] pt  [3];
    logic         pv  [3];
    logic         fe  [3];
    logic         oe  [3];
    logic [4:0]   bc  [3];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    input_interface #(.TIMEOUT(16)) u0 (
        .clk(clk), .rst_(rst_), .data_in(d_in), .data_ok(ok), .input_ready(rdy[0]),
        .plaintext(pt[0]), .plaintext_valid(pv[0]), .plaintext_ack(ack),
        .frame_err(fe[0]), .overrun_err(oe[0]), .byte_count(bc[0]));
    input_interface #(.TIMEOUT(4)) u1 (
        .clk(clk), .rst_(rst_), .data_in(d_in), .data_ok(ok), .input_ready(rdy[1]),
        .plaintext(pt[1]), .plaintext_valid(pv[1]), .plaintext_ack(ack),
        .frame_err(fe[1]), .overrun_err(oe[1]), .byte_count(bc[1]));
    input_interface #(.TIMEOUT(0)) u2 (
        .clk(clk), .rst_(rst_), .data_in(d_in), .data_ok(ok), .input_ready(rdy[2]),
        .plaintext(pt[2]), .plaintext_valid(pv[2]), .plaintext_ack(ack),
        .frame_err(fe[2]), .overrun_err(oe[2]), .byte_count(bc[2]));

    // Model: bytes kept as an ordered list, the block is joined only on hand-off.
    int           m_cnt  [3];
    logic [7:0]   m_b    [3][16];
    int           m_idle [3];
    logic [127:0] m_pt   [3];
    logic         m_pv   [3];
    logic         m_fe   [3];
    logic         m_oe   [3];

    typedef struct {
        logic       ok;
        logic [7:0] d;
        logic       ack;
        logic [4:0] cnt;
        logic       rdy;
        logic       pv;
        logic       oe;
    } vec_t;
    vec_t tbl [20];

    function automatic int tmo(input int i);
        case (i)
            0:       return 16;
            1:       return 4;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d]: got %h expected %h", nm, inst, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_idle[i] = 0; m_pt[i] = '0;
            m_pv[i] = 1'b0; m_fe[i] = 1'b0; m_oe[i] = 1'b0;
            for (int k = 0; k < 16; k++) m_b[i][k] = 8'h00;
        end
    endtask

    task automatic m_step(input int i);
        bit ready;
        bit partial;
        ready   = (m_cnt[i] < 16);
        partial = (m_cnt[i] > 0) && (m_cnt[i] < 16);
        m_fe[i] = 1'b0;
        m_oe[i] = ok && !ready;
        if (m_cnt[i] == 16 && (!m_pv[i] || ack)) begin
            m_pt[i] = '0;
            for (int k = 0; k < 16; k++) m_pt[i] = {m_pt[i][119:0], m_b[i][k]};
            m_pv[i] = 1'b1;
            m_cnt[i] = 0;
        end else begin
            if (m_pv[i] && ack) m_pv[i] = 1'b0;
            if (partial && tmo(i) > 0 && m_idle[i] + 1 == tmo(i)) begin
                m_fe[i] = 1'b1;
                m_cnt[i] = 0;
                m_idle[i] = 0;
            end else if (ok && ready) begin
                m_b[i][m_cnt[i]] = d_in;
                m_cnt[i]++;
                m_idle[i] = 0;
            end else if (partial) begin
                m_idle[i]++;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk("ready", i, 128'(rdy[i]), 128'(m_cnt[i] < 16));
            chk("count", i, 128'(bc[i]), 128'(m_cnt[i]));
            chk("valid", i, 128'(pv[i]), 128'(m_pv[i]));
            chk("plaintext", i, pt[i], m_pt[i]);
            chk("frame_err", i, 128'(fe[i]), 128'(m_fe[i]));
            chk("overrun_err", i, 128'(oe[i]), 128'(m_oe[i]));
        end
    endtask

    task automatic step(input logic [7:0] d, input logic o, input logic a);
        d_in = d; ok = o; ack = a;
        @(posedge clk);
        for (int i = 0; i < 3; i++) m_step(i);
        #1;
        compare_all();
    endtask

    task automatic send_block(input logic [7:0] base);
        for (int k = 0; k < 16; k++) step(8'(base + 8'(k)), 1'b1, 1'b0);
    endtask

    // Reset is raised mid-cycle so its effect is observed before any clock edge.
    task automatic do_reset();
        d_in = 8'h00; ok = 1'b0; ack = 1'b0;
        #1 rst_ = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_count", i, 128'(bc[i]), 128'd0);
            chk("rst_valid", i, 128'(pv[i]), 128'd0);
            chk("rst_plaintext", i, pt[i], 128'd0);
            chk("rst_errs", i, 128'({fe[i], oe[i]}), 128'd0);
            chk("rst_ready", i, 128'(rdy[i]), 128'd1);
        end
        @(posedge clk);
        #1 rst_ = 1'b0;
        m_reset();
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        bit saw;
        int unsigned p;
        logic [4:0] kc;

        for (int k = 0; k < 20; k++) begin
            kc = 5'(k + 1);
            if (k < 16) tbl[k] = '{1'b1, 8'(k), 1'b0, kc, (k < 15), 1'b0, 1'b0};
            else if (k == 16) tbl[k] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0};
            else if (k == 17) tbl[k] = '{1'b1, 8'h55, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0};
            else tbl[k] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0};
        end

        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_ = 1'b0;
        compare_all();

        for (int k = 0; k < 20; k++) begin
            step(tbl[k].d, tbl[k].ok, tbl[k].ack);
            chk("tbl_count", k, 128'(bc[0]), 128'(tbl[k].cnt));
            chk("tbl_ready", k, 128'(rdy[0]), 128'(tbl[k].rdy));
            chk("tbl_valid", k, 128'(pv[0]), 128'(tbl[k].pv));
            chk("tbl_overrun", k, 128'(oe[0]), 128'(tbl[k].oe));
            if (k == 16) chk("first_block", 0, pt[0], 128'h000102030405060708090A0B0C0D0E0F);
        end

        // Two blocks with no ack, then an overrun byte, then one ack.
        do_reset();
        send_block(8'h10);
        step(8'h00, 1'b0, 1'b0);
        send_block(8'h20);
        step(8'hAA, 1'b1, 1'b0);
        chk("ovr_pulse", 0, 128'(oe[0]), 128'd1);
        chk("ovr_count", 0, 128'(bc[0]), 128'd16);
        chk("ovr_ready", 0, 128'(rdy[0]), 128'd0);
        chk("ovr_hold_a", 0, pt[0], 128'h101112131415161718191A1B1C1D1E1F);
        step(8'h00, 1'b0, 1'b0);
        chk("ovr_once", 0, 128'(oe[0]), 128'd0);
        step(8'h00, 1'b0, 1'b1);
        chk("ack_b", 0, pt[0], 128'h202122232425262728292A2B2C2D2E2F);
        chk("ack_b_valid", 0, 128'(pv[0]), 128'd1);
        chk("ack_b_count", 0, 128'(bc[0]), 128'd0);

        // Ack on the first edge the second block can move.
        do_reset();
        send_block(8'h60);
        step(8'h00, 1'b0, 1'b0);
        saw = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(8'(8'h70 + 8'(k)), 1'b1, 1'b0);
            if (!pv[0]) saw = 1'b1;
        end
        step(8'h00, 1'b0, 1'b1);
        if (!pv[0]) saw = 1'b1;
        chk("same_edge_no_drop", 0, 128'(saw), 128'd0);
        chk("same_edge_block", 0, pt[0], 128'h707172737475767778797A7B7C7D7E7F);

        // Gap timeout on the TIMEOUT=4 instance.
        do_reset();
        for (int k = 1; k <= 5; k++) step(8'(k), 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(8'h00, 1'b0, 1'b0);
            chk("tmo_pulse", 1, 128'(fe[1]), 128'(k == 4));
            if (k == 4) chk("tmo_count", 1, 128'(bc[1]), 128'd0);
        end
        send_block(8'hF0);
        step(8'h00, 1'b0, 1'b0);
        chk("tmo_clean_block", 1, pt[1], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        chk("tmo_clean_valid", 1, 128'(pv[1]), 128'd1);

        // A byte landing on the timeout edge is discarded, not an overrun.
        do_reset();
        for (int k = 1; k <= 5; k++) step(8'(k), 1'b1, 1'b0);
        repeat (3) step(8'h00, 1'b0, 1'b0);
        step(8'h77, 1'b1, 1'b0);
        chk("tmo_edge_frame", 1, 128'(fe[1]), 128'd1);
        chk("tmo_edge_count", 1, 128'(bc[1]), 128'd0);
        chk("tmo_edge_ovr", 1, 128'(oe[1]), 128'd0);

        // Reset mid-block and mid-handshake.
        do_reset();
        for (int k = 0; k < 9; k++) step(8'(k), 1'b1, 1'b0);
        do_reset();
        send_block(8'h10);
        step(8'h00, 1'b0, 1'b0);
        chk("pre_rst_valid", 0, 128'(pv[0]), 128'd1);
        do_reset();
        step(8'h30, 1'b1, 1'b0);
        chk("post_rst_byte1", 0, 128'(bc[0]), 128'd1);
        for (int k = 1; k < 16; k++) step(8'(8'h30 + 8'(k)), 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("post_rst_block", 0, pt[0], 128'h303132333435363738393A3B3C3D3E3F);

        // Long gap with the timeout disabled.
        do_reset();
        for (int k = 0; k < 3; k++) step(8'(8'h40 + 8'(k)), 1'b1, 1'b0);
        saw = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step(8'h00, 1'b0, 1'b0);
            if (fe[2]) saw = 1'b1;
        end
        chk("t0_no_frame", 2, 128'(saw), 128'd0);
        chk("t0_count", 2, 128'(bc[2]), 128'd3);
        for (int k = 3; k < 16; k++) step(8'(8'h40 + 8'(k)), 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        chk("t0_block", 2, pt[2], 128'h404142434445464748494A4B4C4D4E4F);

        // Random traffic with bursty arrival rates and occasional reset.
        do_reset();
        p = 90;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(2))
                    0:       p = 97;
                    1:       p = 50;
                    default: p = 5;
                endcase
            end
            if ($urandom_range(999) == 0) do_reset();
            step(8'($urandom), ($urandom_range(99) < p), ($urandom_range(99) < 35));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/input_interface.md
Name: input_interface

Overview:
Byte-serial ingress for the AES engine, the receive-side counterpart of the ciphertext serializer. It collects 16 bytes, most-significant byte first, into a 128-bit plaintext block and hands the block to the round transformer with a valid/ack handshake. A second holding stage lets one full block wait for the engine while the next block is refused. The block also detects inter-byte gap timeouts and overrun bytes.

Parameters:
TIMEOUT, 16, idle cycles allowed between bytes inside a partial block before it is discarded; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
rst_  input  1  asynchronous reset, active-high
data_in  input  8  incoming byte
data_ok  input  1  data_in valid this cycle
input_ready  output  1  block can accept a byte this cycle
plaintext  output  128  assembled block; first byte received is in [127:120]
plaintext_valid  output  1  plaintext holds an unconsumed block
plaintext_ack  input  1  engine has consumed plaintext; sampled only while plaintext_valid=1
frame_err  output  1  one-cycle pulse: partial block discarded on timeout
overrun_err  output  1  one-cycle pulse: byte dropped because input_ready=0
byte_count  output  5  bytes currently in the assembly register (0-16)

Behaviour:
- Reset (async, rst_=1): assembly register, plaintext, byte_count, gap counter, plaintext_valid, frame_err and overrun_err all go to 0.
- input_ready is combinational: byte_count<16.
- Byte accept, when data_ok=1 and input_ready=1 at an edge:
  - asm <= {asm[119:0], data_in}
  - byte_count increments
  - gap counter clears
- Assembler states are implied by byte_count:
  - EMPTY (0)
  - COLLECT (1-15)
  - FULL (16)
- Transfer, at an edge where byte_count==16 and (plaintext_valid==0 or plaintext_ack==1):
  - plaintext <= asm; plaintext_valid <= 1; byte_count <= 0.
  - The transfer edge never coincides with a byte accept, because input_ready=0 while FULL.
- Latency: with the 16th byte accepted at edge E and the output stage free, plaintext_valid=1 after edge E+1. input_ready returns to 1 after edge E+1, so there is one bubble cycle per block.
- Handshake:
  - plaintext_valid stays 1 and plaintext stays stable until plaintext_ack=1 is sampled.
  - Ack with no pending transfer clears plaintext_valid.
  - Ack at the same edge as a transfer: plaintext is replaced and plaintext_valid stays 1.
  - Ack while plaintext_valid=0 is ignored.
- Back-pressure: FULL with plaintext_valid=1 and no ack holds asm and byte_count indefinitely, with input_ready=0.
- Overrun: data_ok=1 while input_ready=0 drops the byte, leaves asm unchanged, and sets overrun_err=1 for the following cycle only.
- Gap timeout (TIMEOUT>0):
  - While byte_count is 1-15 and no byte is accepted, the gap counter increments each cycle.
  - When it reaches TIMEOUT, at that edge: byte_count<=0, asm<=0, gap counter<=0, frame_err=1 for one cycle.
  - A byte arriving on the timeout edge is discarded together with the partial block; it does not count as an overrun.
- The gap counter is held at 0 while byte_count is 0 or 16. Width is ceil(log2(TIMEOUT+1)), minimum 1.
- Reset mid-block or mid-handshake aborts everything immediately. After release, the first data_ok byte lands as byte 1.
- Error pulses and plaintext_valid are registered outputs.

Test Plan:
- Bytes 0x00..0x0F on 16 consecutive cycles, ack tied 0 -> after edge 17: plaintext=0x000102030405060708090A0B0C0D0E0F, plaintext_valid=1, byte_count=0, input_ready=1.
- Ack held low; send block A (0x10..0x1F) then block B (0x20..0x2F), then a 33rd byte 0xAA -> input_ready=0, byte_count=16, overrun_err pulses once, plaintext=A. Raise ack for one cycle -> next edge plaintext=B, valid stays 1, byte_count=0.
- TIMEOUT=4; send 5 bytes then idle -> frame_err pulses exactly once 4 cycles after the last byte, byte_count=0. The next 16 bytes 0xF0..0xFF produce plaintext 0xF0F1...FF with no stale bytes.
- Block pending; ack asserted on the same edge a second block transfers -> plaintext_valid never drops, and plaintext switches to the second block.
- Assert rst_ for one cycle after 9 bytes and again while plaintext_valid=1 -> all outputs 0 asynchronously. A following clean 16-byte block assembles correctly.
- TIMEOUT=0 with a 100-cycle gap after byte 3 -> no frame_err, and the block completes normally when bytes resume.
